// File: rtl/pcie_rx_symbol_decoder_if.sv
// Symbol-in / classified-symbol-out bundle for the RX symbol decoder.
// The link side (master) drives symbols; the decoder (slave) reports.
interface pcie_rx_symbol_decoder_if #(
  parameter int LEN_W = 13
);
  logic             ENB;
  logic [7:0]       IN_SYM;
  logic             IN_K;
  logic [3:0]       OUT_CTRL;
  logic [7:0]       OUT_DATA;
  logic             OUT_VALID;
  logic             PKT_DVLD;
  logic             PKT_SOP;
  logic             PKT_EOP;
  logic             PKT_ABORT;
  logic             PKT_IS_DLLP;
  logic [LEN_W-1:0] PKT_LEN;
  logic             ERR_FRAME;

  modport master (
    output ENB, IN_SYM, IN_K,
    input  OUT_CTRL, OUT_DATA, OUT_VALID,
    input  PKT_DVLD, PKT_SOP, PKT_EOP,
    input  PKT_ABORT, PKT_IS_DLLP,
    input  PKT_LEN, ERR_FRAME
  );

  modport slave (
    input  ENB, IN_SYM, IN_K,
    output OUT_CTRL, OUT_DATA, OUT_VALID,
    output PKT_DVLD, PKT_SOP, PKT_EOP,
    output PKT_ABORT, PKT_IS_DLLP,
    output PKT_LEN, ERR_FRAME
  );
endinterface

// File: rtl/pcie_rx_symbol_decoder.sv
// RX symbol classifier and TLP/DLLP/ordered-set framer.
// All outputs are registered: one cycle after the enabled symbol.
module pcie_rx_symbol_decoder #(
  parameter logic [7:0]  K_COM    = 8'hF2,
  parameter logic [7:0]  K_PAD    = 8'hC7,
  parameter logic [7:0]  K_SKP    = 8'hAC,
  parameter logic [7:0]  K_STP    = 8'hAA,
  parameter logic [7:0]  K_SDP    = 8'hE5,
  parameter logic [7:0]  K_END    = 8'hF6,
  parameter logic [7:0]  K_EDB    = 8'hDF,
  parameter logic [7:0]  K_FTS    = 8'hA8,
  parameter logic [7:0]  K_IDL    = 8'hAE,
  parameter logic [15:0] MAX_TLP  = 16'd4096,
  parameter int          DLLP_LEN = 6,
  parameter int          LEN_W    = 13
) (
  input  logic CLK_2MHz,
  input  logic reset,
  pcie_rx_symbol_decoder_if.slave bus
);

  localparam logic [3:0] C_DATA = 4'd0;
  localparam logic [3:0] C_COM  = 4'd1;
  localparam logic [3:0] C_PAD  = 4'd2;
  localparam logic [3:0] C_SKP  = 4'd3;
  localparam logic [3:0] C_STP  = 4'd4;
  localparam logic [3:0] C_SDP  = 4'd5;
  localparam logic [3:0] C_END  = 4'd6;
  localparam logic [3:0] C_EDB  = 4'd7;
  localparam logic [3:0] C_FTS  = 4'd8;
  localparam logic [3:0] C_IDL  = 4'd9;
  localparam logic [3:0] C_BAD  = 4'd15;

  localparam logic [LEN_W-1:0] TLP_MAX =
    LEN_W'(MAX_TLP);
  localparam logic [LEN_W-1:0] DLLP_MAX =
    LEN_W'(DLLP_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_TLP, S_DLLP, S_OS, S_DROP
  } state_t;

  state_t           state, state_n;
  logic [1:0]       os_cnt, os_n;
  logic [LEN_W-1:0] len, len_n, lim;
  logic             dllp, dllp_n;
  logic [3:0]       code, ctrl_q;
  logic [7:0]       data_q;
  logic             vld_q;
  logic             dvld_n, sop_n, eop_n;
  logic             abort_n, err_n;
  logic             dvld_q, sop_q, eop_q;
  logic             abort_q, err_q;
  logic             start, in_pkt, len_ok;

  // Map the raw symbol onto its CTRL code.
  always_comb begin
    code = C_BAD;
    if (!bus.IN_K) begin
      code = C_DATA;
    end else begin
      unique case (1'b1)
        bus.IN_SYM == K_COM: code = C_COM;
        bus.IN_SYM == K_PAD: code = C_PAD;
        bus.IN_SYM == K_SKP: code = C_SKP;
        bus.IN_SYM == K_STP: code = C_STP;
        bus.IN_SYM == K_SDP: code = C_SDP;
        bus.IN_SYM == K_END: code = C_END;
        bus.IN_SYM == K_EDB: code = C_EDB;
        bus.IN_SYM == K_FTS: code = C_FTS;
        bus.IN_SYM == K_IDL: code = C_IDL;
        default:             code = C_BAD;
      endcase
    end
  end

  // Framing FSM: next state, counters and pulses.
  always_comb begin
    state_n = state;
    os_n    = os_cnt;
    len_n   = len;
    dllp_n  = dllp;
    dvld_n  = 1'b0;
    sop_n   = 1'b0;
    eop_n   = 1'b0;
    abort_n = 1'b0;
    err_n   = 1'b0;
    start   = (code == C_STP) || (code == C_SDP);
    in_pkt  = (state == S_TLP) || (state == S_DLLP);
    lim     = (state == S_DLLP) ? DLLP_MAX : TLP_MAX;
    len_ok  = (state == S_DLLP) ? (len == DLLP_MAX)
            : (len != '0) && (len <= TLP_MAX);
    if (bus.ENB) begin
      err_n = (code == C_BAD);
      if (start) begin
        state_n = (code == C_SDP) ? S_DLLP : S_TLP;
        dllp_n  = (code == C_SDP);
        sop_n   = 1'b1;
        len_n   = '0;
        // A new start cuts short whatever was open.
        if (in_pkt) begin
          err_n   = 1'b1;
          abort_n = 1'b1;
        end
        if (state == S_OS) err_n = 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (code == C_COM) begin
              state_n = S_OS;
              os_n    = 2'd0;
            end else if (code inside
                         {C_DATA, C_END, C_EDB}) begin
              err_n = 1'b1;
            end
          end
          S_TLP, S_DLLP: begin
            if (code == C_DATA) begin
              if (len == lim) begin
                state_n = S_DROP;
                err_n   = 1'b1;
                abort_n = 1'b1;
              end else begin
                dvld_n = 1'b1;
                len_n  = len + 1'b1;
              end
            end else if (code == C_END) begin
              state_n = S_IDLE;
              eop_n   = len_ok;
              abort_n = !len_ok;
              err_n   = !len_ok;
            end else if (code == C_EDB) begin
              state_n = S_IDLE;
              abort_n = 1'b1;
            end else begin
              state_n = S_IDLE;
              err_n   = 1'b1;
              abort_n = 1'b1;
            end
          end
          S_OS: begin
            if (code == C_COM) begin
              os_n = 2'd0;
            end else if (code inside
                         {C_SKP, C_FTS, C_IDL}) begin
              if (os_cnt == 2'd2) state_n = S_IDLE;
              else os_n = os_cnt + 2'd1;
            end else begin
              state_n = S_IDLE;
              err_n   = 1'b1;
            end
          end
          S_DROP: begin
            if (code inside {C_END, C_EDB})
              state_n = S_IDLE;
          end
          default: state_n = S_IDLE;
        endcase
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK_2MHz or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      os_cnt  <= 2'd0;
      len     <= '0;
      dllp    <= 1'b0;
      ctrl_q  <= 4'd0;
      data_q  <= 8'd0;
      vld_q   <= 1'b0;
      dvld_q  <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      os_cnt  <= os_n;
      len     <= len_n;
      dllp    <= dllp_n;
      vld_q   <= bus.ENB;
      dvld_q  <= dvld_n;
      sop_q   <= sop_n;
      eop_q   <= eop_n;
      abort_q <= abort_n;
      err_q   <= err_n;
      if (bus.ENB) begin
        ctrl_q <= code;
        data_q <= bus.IN_SYM;
      end
    end
  end

  assign bus.OUT_CTRL    = ctrl_q;
  assign bus.OUT_DATA    = data_q;
  assign bus.OUT_VALID   = vld_q;
  assign bus.PKT_DVLD    = dvld_q;
  assign bus.PKT_SOP     = sop_q;
  assign bus.PKT_EOP     = eop_q;
  assign bus.PKT_ABORT   = abort_q;
  assign bus.PKT_IS_DLLP = dllp;
  assign bus.PKT_LEN     = len;
  assign bus.ERR_FRAME   = err_q;

endmodule
